alu_dispatch: RTL

ALU_DISPATCH -- requirements
Module: alu_dispatch

---
 rtl/alu_dispatch.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_dispatch.sv
// Four-bank request dispatcher in front of a four-lane ALU. Requests go to the lowest
// free bank; silent lanes time out, and completed results return round-robin.
module alu_dispatch #(
    parameter int unsigned TIMEOUT = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_command,
    input  logic [31:0]      req_data1,
    input  logic [31:0]      req_data2,
    input  logic [3:0]       req_tag,
    output logic [3:0][65:0] input_packet,
    input  logic [3:0][33:0] output_packet,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [1:0]       rsp_response,
    output logic [31:0]      rsp_data,
    output logic [3:0]       rsp_tag,
    output logic [1:0]       rsp_bank,
    output logic [3:0]       bank_busy,
    output logic [15:0]      timeout_count
);
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } bank_state_e;

    localparam logic [1:0] CMD_NOP     = 2'd0;
    localparam logic [1:0] RSP_NONE    = 2'd0;
    localparam logic [1:0] RSP_TIMEOUT = 2'd3;
    localparam logic [3:0] WAIT_LIMIT  = 4'(TIMEOUT);

    bank_state_e state_r [4];
    bank_state_e state_s [4];
    logic [3:0]  wcnt_r  [4];
    logic [3:0]  tag_r   [4];
    logic [1:0]  resp_r  [4];
    logic [31:0] rdata_r [4];
    logic [65:0] pkt_r   [4];
    logic [1:0]  ptr_r;
    logic [1:0]  sel_r;
    logic        lock_r;
    logic [15:0] tocnt_r;

    logic [3:0]  idle_s, done_s, alloc_s, hit_s, expire_s, release_s;
    logic        dispatch_s, alloc_found_s, rr_found_s, handshake_s;
    logic [1:0]  rr_sel_s, rr_idx_s, sel_s;

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        popcount4 = 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [2:0] inc);
        logic [16:0] sum;
        sum = {1'b0, a} + {14'd0, inc};
        sat_add16 = sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Per-bank status decode and lowest-free-bank allocation.
    always_comb begin
        idle_s        = 4'b0000;
        done_s        = 4'b0000;
        hit_s         = 4'b0000;
        expire_s      = 4'b0000;
        alloc_s       = 4'b0000;
        alloc_found_s = 1'b0;
        for (int b = 0; b < 4; b++) begin
            idle_s[b]     = (state_r[b] == ST_IDLE);
            done_s[b]     = (state_r[b] == ST_DONE);
            hit_s[b]      = (state_r[b] == ST_WAIT) && (output_packet[b][33:32] != RSP_NONE);
            expire_s[b]   = (state_r[b] == ST_WAIT) && !hit_s[b] && (wcnt_r[b] >= WAIT_LIMIT);
            alloc_s[b]    = idle_s[b] && !alloc_found_s;
            alloc_found_s = alloc_found_s | idle_s[b];
        end
        req_ready  = |idle_s;
        dispatch_s = req_valid && req_ready && (req_command != CMD_NOP);
    end

    // Round-robin pick among DONE banks; a presented result stays frozen until taken.
    always_comb begin
        rr_found_s = 1'b0;
        rr_sel_s   = 2'd0;
        rr_idx_s   = 2'd0;
        for (int k = 0; k < 4; k++) begin
            rr_idx_s   = ptr_r + 2'(k);
            rr_sel_s   = (done_s[rr_idx_s] && !rr_found_s) ? rr_idx_s : rr_sel_s;
            rr_found_s = rr_found_s | done_s[rr_idx_s];
        end
        sel_s            = lock_r ? sel_r : rr_sel_s;
        rsp_valid        = |done_s;
        handshake_s      = rsp_valid && rsp_ready;
        release_s        = 4'b0000;
        release_s[sel_s] = handshake_s;
        rsp_response     = rsp_valid ? resp_r[sel_s]  : 2'd0;
        rsp_data         = rsp_valid ? rdata_r[sel_s] : 32'd0;
        rsp_tag          = rsp_valid ? tag_r[sel_s]   : 4'd0;
        rsp_bank         = rsp_valid ? sel_s          : 2'd0;
    end

    // Bank FSM next-state.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            state_s[b] = state_r[b];
            case (state_r[b])
                ST_IDLE: begin
                    if (alloc_s[b] && dispatch_s) begin
                        state_s[b] = ST_WAIT;
                    end else begin
                        state_s[b] = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (hit_s[b] || expire_s[b]) begin
                        state_s[b] = ST_DONE;
                    end else begin
                        state_s[b] = ST_WAIT;
                    end
                end
                ST_DONE: begin
                    if (release_s[b]) begin
                        state_s[b] = ST_IDLE;
                    end else begin
                        state_s[b] = ST_DONE;
                    end
                end
                default: state_s[b] = ST_IDLE;
            endcase
        end
    end

    // Bank state, ALU-facing packet and captured result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int b = 0; b < 4; b++) begin
                state_r[b] <= ST_IDLE;
                wcnt_r[b]  <= 4'd0;
                tag_r[b]   <= 4'd0;
                resp_r[b]  <= 2'd0;
                rdata_r[b] <= 32'd0;
                pkt_r[b]   <= 66'd0;
            end
        end else begin
            for (int b = 0; b < 4; b++) begin
                state_r[b] <= state_s[b];
                case (state_r[b])
                    ST_IDLE: begin
                        if (alloc_s[b] && dispatch_s) begin
                            pkt_r[b]  <= {req_command, req_data1, req_data2};
                            tag_r[b]  <= req_tag;
                            wcnt_r[b] <= 4'd1;
                        end
                    end
                    ST_WAIT: begin
                        // An ALU answer wins over an expiry landing on the same cycle.
                        if (hit_s[b]) begin
                            resp_r[b]  <= output_packet[b][33:32];
                            rdata_r[b] <= output_packet[b][31:0];
                            pkt_r[b]   <= 66'd0;
                        end else if (expire_s[b]) begin
                            resp_r[b]  <= RSP_TIMEOUT;
                            rdata_r[b] <= 32'd0;
                            pkt_r[b]   <= 66'd0;
                        end else begin
                            wcnt_r[b]  <= wcnt_r[b] + 4'd1;
                        end
                    end
                    ST_DONE: ;
                    default: ;
                endcase
            end
        end
    end

    // Round-robin pointer, presentation lock and saturating timeout counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_r   <= 2'd0;
            sel_r   <= 2'd0;
            lock_r  <= 1'b0;
            tocnt_r <= 16'd0;
        end else begin
            lock_r  <= rsp_valid && !rsp_ready;
            sel_r   <= sel_s;
            tocnt_r <= sat_add16(tocnt_r, popcount4(expire_s));
            if (handshake_s) begin
                ptr_r <= sel_s + 2'd1;
            end
        end
    end

    // Packets are held in registers so the ALU sees stable operands.
    always_comb begin
        for (int b = 0; b < 4; b++) begin
            input_packet[b] = pkt_r[b];
        end
    end

    assign bank_busy     = ~idle_s;
    assign timeout_count = tocnt_r;

endmodule
